param_counter_bank: RTL
=======================

Name: param_counter_bank

Overview:
Multi-channel up/down counter bank. It is the parametrised successor of the single-instance bit/int-parameter DUT used in the VPI parameter examples. Channel count, width, step, reset value and overflow mode are all parameters, so the VPI examples can iterate vpiParameter/vpiParamAssign over a realistic instance. RESET_VALUE is intended to be driven from a part-select of an enclosing localparam. The block also provides a handshaked per-channel load port.

Parameters:
NUM_CHANNELS, 4, number of independent counters (1..16)
WIDTH, 8, counter width in bits (2..32)
STEP, 1, increment/decrement magnitude, 1..2^WIDTH-1
SATURATE, 1'b0, bit param: 1 = clamp at 0 / max, 0 = modulo wrap
RESET_VALUE, 0, value on rst and on clear, truncated to WIDTH LSBs

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
en  in  NUM_CHANNELS  per-channel count enable
dir  in  NUM_CHANNELS  per-channel direction, 1 = up, 0 = down
clear  in  NUM_CHANNELS  per-channel synchronous reload of RESET_VALUE
load_valid  in  1  load request
load_ready  out  1  load port can accept
load_chan  in  max(1,$clog2(NUM_CHANNELS))  target channel
load_data  in  WIDTH  value to load
load_err  out  1  one-cycle pulse: accepted load had load_chan >= NUM_CHANNELS
count  out  NUM_CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
event_pulse  out  NUM_CHANNELS  one-cycle pulse: channel overflowed/underflowed this update

Behaviour:
- Reset is asynchronous and active-high. While rst = 1: every count = RESET_VALUE[WIDTH-1:0], event_pulse = 0, load_err = 0, load_ready = 0, FSM = IDLE. load_ready rises on the first clock edge after rst deasserts.
- Load FSM has 2 states, IDLE and COMMIT.
  - IDLE: load_ready = 1. On load_valid & load_ready, capture load_chan/load_data into holding regs and go to COMMIT.
  - COMMIT: load_ready = 0 for exactly one cycle. Write the held data to the held channel on this edge, then return to IDLE.
  - Maximum throughput is one load per 2 cycles.
- Out-of-range channel: a load with load_chan >= NUM_CHANNELS is still accepted (handshake completes). No counter changes, and load_err pulses 1 in the COMMIT cycle.
- Per-channel update priority each cycle, highest first: clear, then commit-load to this channel, then en-count, then hold. A lower-priority action on the same cycle is dropped with no pulse.
- Count arithmetic is done in WIDTH+1 bits.
  - Up: s = count + STEP. If s >= 2^WIDTH: new = SATURATE ? 2^WIDTH-1 : s mod 2^WIDTH, and event_pulse[i] = 1.
  - Down: if count < STEP: new = SATURATE ? 0 : (count - STEP) mod 2^WIDTH, and event_pulse[i] = 1. Otherwise new = count - STEP.
  - Saturated channel held at its limit with en still asserted: event_pulse stays 1 on every such cycle.
- event_pulse is registered and valid the cycle after the update edge. It is never set by clear or load.
- Latency: count reflects en/clear one cycle after the sampling edge, and load two edges after acceptance.
- Reset mid-operation: rst during COMMIT aborts the load. The held data is discarded and no load_err is raised.
- NUM_CHANNELS = 1: load_chan is 1 bit; any value 1 is out of range.
- Elaboration: STEP == 0 or STEP >= 2^WIDTH is a fatal error.

Test Plan:
- Reset: NUM_CHANNELS=4, WIDTH=8, RESET_VALUE='h1234 >> 8 (so 'h12). Assert rst → all count = 'h12, load_ready = 0; after release, load_ready = 1 on the next edge.
- Wrap up: SATURATE=0, STEP=1. Load ch0 = 'hFE, then en[0]=1, dir=1 for 3 cycles → count0 = FF, 00, 01. event_pulse[0] = 1 only in the cycle after the FF→00 edge.
- Saturate down: SATURATE=1, STEP=3. ch2 = 'h04, en[2]=1, dir=0 for 3 cycles → count2 = 01, 00, 00. event_pulse[2] = 0, 1, 1.
- Priority: same cycle clear[1]=1, en[1]=1, and a commit of 'h55 to ch1 → count1 = 'h12, no pulse. Next cycle en only → 'h13.
- Handshake: load_valid held high for 4 cycles with chan 0,1,2,3 → exactly 2 accepts (cycles 0 and 2). load_ready pattern 1,0,1,0. Values land two edges after each accept.
- Bad channel and reset abort: NUM_CHANNELS=3, load_chan=3 → accepted, load_err = 1 for one cycle, counts unchanged. Separately, rst asserted in COMMIT → no counter written, load_err stays 0.

Source files
------------

// File: rtl/param_counter_bank_if.sv
// Load/count bus for param_counter_bank: per-channel controls, load handshake, counter outputs.
interface param_counter_bank_if #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned WIDTH        = 8
);
    localparam int unsigned CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [NUM_CHANNELS-1:0]       en;
    logic [NUM_CHANNELS-1:0]       dir;
    logic [NUM_CHANNELS-1:0]       clear;
    logic                          load_valid;
    logic                          load_ready;
    logic [CHAN_W-1:0]             load_chan;
    logic [WIDTH-1:0]              load_data;
    logic                          load_err;
    logic [NUM_CHANNELS*WIDTH-1:0] count;
    logic [NUM_CHANNELS-1:0]       event_pulse;

    modport master (
        output en, dir, clear, load_valid, load_chan, load_data,
        input  load_ready, load_err, count, event_pulse
    );

    modport slave (
        input  en, dir, clear, load_valid, load_chan, load_data,
        output load_ready, load_err, count, event_pulse
    );
endinterface

// File: rtl/param_counter_bank.sv
// Multi-channel up/down counter bank with wrap/saturate overflow and a two-state handshaked load port.
module param_counter_bank #(
    parameter int unsigned     NUM_CHANNELS = 4,
    parameter int unsigned     WIDTH        = 8,
    parameter longint unsigned STEP         = 1,
    parameter bit              SATURATE     = 1'b0,
    parameter longint unsigned RESET_VALUE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    param_counter_bank_if.slave   bank_if
);
    localparam int unsigned       CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [WIDTH:0]    STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0]  RST_V  = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0]  MAX_V  = {WIDTH{1'b1}};

    // Reject step values that cannot be represented in the counter width.
    if (STEP == 0 || STEP >= (64'd1 << WIDTH)) begin : g_bad_step
        $fatal(1, "param_counter_bank: STEP must be in 1..2^WIDTH-1");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic [CHAN_W-1:0]       chan_q;
    logic [WIDTH-1:0]        data_q;
    logic [WIDTH-1:0]        cnt_q [NUM_CHANNELS];
    logic [WIDTH-1:0]        cnt_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] evt_q, evt_d;
    logic                    accept_c;
    logic                    commit_c;
    logic                    chan_bad_c;

    // Load FSM state, ready flag, error pulse and holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            chan_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            if (accept_c) begin
                chan_q <= bank_if.load_chan;
                data_q <= bank_if.load_data;
            end
        end
    end

    // Next-state and handshake decode: accept in IDLE, write during COMMIT.
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        commit_c   = 1'b0;
        chan_bad_c = (32'(bank_if.load_chan) >= NUM_CHANNELS);
        case (state_q)
            IDLE: begin
                if (bank_if.load_valid && ready_q) begin
                    accept_c = 1'b1;
                    state_d  = COMMIT;
                end
            end
            COMMIT: begin
                commit_c = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        err_d   = accept_c && chan_bad_c;
    end

    // Counter and event registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
                cnt_q[i] <= RST_V;
            end
            evt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    // Per-channel update: clear beats commit-load beats count; only counting raises events.
    always_comb begin
        logic [WIDTH:0] sum;
        logic [WIDTH:0] diff;
        cnt_d = cnt_q;
        evt_d = '0;
        sum   = '0;
        diff  = '0;
        for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
            sum  = {1'b0, cnt_q[i]} + STEP_W;
            diff = {1'b0, cnt_q[i]} - STEP_W;
            if (bank_if.clear[i]) begin
                cnt_d[i] = RST_V;
            end else if (commit_c && (32'(chan_q) == 32'(i))) begin
                cnt_d[i] = data_q;
            end else if (bank_if.en[i]) begin
                if (bank_if.dir[i]) begin
                    evt_d[i] = sum[WIDTH];
                    cnt_d[i] = (sum[WIDTH] && SATURATE) ? MAX_V : sum[WIDTH-1:0];
                end else begin
                    evt_d[i] = diff[WIDTH];
                    cnt_d[i] = (diff[WIDTH] && SATURATE) ? '0 : diff[WIDTH-1:0];
                end
            end
        end
    end

    // Drive the bus outputs straight from registers.
    always_comb begin
        for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
            bank_if.count[i*WIDTH +: WIDTH] = cnt_q[i];
        end
        bank_if.event_pulse = evt_q;
        bank_if.load_ready  = ready_q;
        bank_if.load_err    = err_q;
    end
endmodule
